// File: rtl/vga_feeder_pkg.sv
// vga_feeder_pkg
//   Shared definitions for the VGA pixel feeder:
//     - feederState_t : FSM state encoding (WAIT_SOF=0, FILL=1, STREAM=2, FLUSH=3)
//     - RGB565 field bit positions
//     - rgb888_t      : expanded 8-bit-per-channel pixel
//     - expand565()   : RGB565 -> RGB888 by MSB replication
//     - barColour()   : 8-entry colour-bar table (used only when VGA_FEEDER_PATTERN_EN is defined)
package vga_feeder_pkg;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    FILL     = 2'd1,
    STREAM   = 2'd2,
    FLUSH    = 2'd3
  } feederState_t;

  localparam int R_HI = 15;
  localparam int R_LO = 11;
  localparam int G_HI = 10;
  localparam int G_LO = 5;
  localparam int B_HI = 4;
  localparam int B_LO = 0;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb888_t;

  // Replicating the top bits into the new LSBs maps full-scale to 0xFF and zero to 0x00.
  function automatic rgb888_t expand565(input logic [15:0] word);
    rgb888_t px;
    px.red   = {word[R_HI:R_LO], word[R_HI:R_HI-2]};
    px.green = {word[G_HI:G_LO], word[G_HI:G_HI-1]};
    px.blue  = {word[B_HI:B_LO], word[B_HI:B_HI-2]};
    return px;
  endfunction

  // Classic test-card order: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic rgb888_t barColour(input logic [2:0] idx);
    rgb888_t px;
    case (idx)
      3'd0:    px = '{8'hFF, 8'hFF, 8'hFF};
      3'd1:    px = '{8'hFF, 8'hFF, 8'h00};
      3'd2:    px = '{8'h00, 8'hFF, 8'hFF};
      3'd3:    px = '{8'h00, 8'hFF, 8'h00};
      3'd4:    px = '{8'hFF, 8'h00, 8'hFF};
      3'd5:    px = '{8'hFF, 8'h00, 8'h00};
      3'd6:    px = '{8'h00, 8'h00, 8'hFF};
      default: px = '{8'h00, 8'h00, 8'h00};
    endcase
    return px;
  endfunction

endpackage

// File: rtl/vga_feeder_fifo.sv
// vga_feeder_fifo
//   Synchronous single-clock FIFO, DEPTH x 16, memory inferred as block RAM with a registered read.
//   Ports:
//     iCLK, iRST_N       clock, asynchronous active-low reset (pointers/count only)
//     iWrite, iWr_Data   write strobe and data (ignored when full)
//     iRead              read strobe (ignored when empty); oRd_Data valid the following cycle
//     iFlush             synchronous clear of pointers and count (has priority)
//     oCount             words held, 0..DEPTH
//     oFull, oEmpty      status flags derived from oCount
module vga_feeder_fifo #(
  parameter int DEPTH = 512
) (
  input  logic                       iCLK,
  input  logic                       iRST_N,
  input  logic                       iWrite,
  input  logic [15:0]                iWr_Data,
  input  logic                       iRead,
  input  logic                       iFlush,
  output logic [15:0]                oRd_Data,
  output logic [$clog2(DEPTH):0]     oCount,
  output logic                       oFull,
  output logic                       oEmpty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wrPtrReg;
  logic [AW-1:0] rdPtrReg;
  logic [CW-1:0] countReg;
  logic [15:0]   rdDataReg;
  logic          wrEn;
  logic          rdEn;

  assign oFull  = (countReg == CW'(DEPTH));
  assign oEmpty = (countReg == '0);
  assign wrEn   = iWrite & ~oFull & ~iFlush;
  assign rdEn   = iRead & ~oEmpty & ~iFlush;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else if (iFlush) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      if (wrEn) wrPtrReg <= wrPtrReg + 1'b1;
      if (rdEn) rdPtrReg <= rdPtrReg + 1'b1;
      case ({wrEn, rdEn})
        2'b10:   countReg <= countReg + 1'b1;
        2'b01:   countReg <= countReg - 1'b1;
        default: countReg <= countReg;
      endcase
    end
  end

  // Memory and read register carry no reset so they map onto block RAM.
  // A read never targets the slot being written: empty blocks reads, full blocks writes.
  always_ff @(posedge iCLK) begin
    if (wrEn) mem[wrPtrReg] <= iWr_Data;
  end

  always_ff @(posedge iCLK) begin
    if (rdEn) rdDataReg <= mem[rdPtrReg];
  end

  assign oRd_Data = rdDataReg;
  assign oCount   = countReg;

endmodule

// File: rtl/vga_pixel_feeder.sv
// vga_pixel_feeder
//   Pixel buffer between the SDRAM frame reader and VGA_Controller. Buffers RGB565 words, aligns to
//   start-of-frame, prefills, then returns one pixel per request with one cycle of latency, expanded
//   to 8-bit R/G/B. Flushes on frame done and flags underflow and short/long frames.
//   Ports:
//     iCLK, iRST_N                          pixel clock, asynchronous active-low reset
//     iIn_Data/iIn_Valid/iIn_SOF/oIn_Ready  RGB565 input stream with start-of-frame marker
//     iRequest, iFrameDone                  pixel request and end-of-frame strobe from the controller
//     iVideo_W, iVideo_H                    active frame size used for the frame length check
//     oRed, oGreen, oBlue                   pixel out, zero on cycles that did not pop
//     oUnderflow                            sticky, set by a request with the FIFO empty in STREAM
//     oUnder_Cnt                            saturating count of such requests in the current frame
//     oFrame_Err                            pops in the last frame differed from W*H
//     oState                                FSM state for debug
//     iPattern                              only with VGA_FEEDER_PATTERN_EN: replace popped pixels
//                                           with 8 vertical colour bars
//   Optional feature macro: VGA_FEEDER_PATTERN_EN
module vga_pixel_feeder
  import vga_feeder_pkg::*;
#(
  parameter int DEPTH   = 512,
  parameter int PREFILL = 256,
  parameter int UCNT_W  = 16
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [15:0]       iIn_Data,
  input  logic              iIn_Valid,
  input  logic              iIn_SOF,
  output logic              oIn_Ready,
  input  logic              iRequest,
  input  logic              iFrameDone,
  input  logic [15:0]       iVideo_W,
  input  logic [15:0]       iVideo_H,
`ifdef VGA_FEEDER_PATTERN_EN
  input  logic              iPattern,
`endif
  output logic [7:0]        oRed,
  output logic [7:0]        oGreen,
  output logic [7:0]        oBlue,
  output logic              oUnderflow,
  output logic [UCNT_W-1:0] oUnder_Cnt,
  output logic              oFrame_Err,
  output logic [1:0]        oState
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] PrefillCnt = CW'(PREFILL);

  feederState_t      stateReg, stateNext;
  logic              readyEnReg;
  logic              inReady;
  logic              wrEn, rdEn, flushEn;
  logic              underEv, sofStart, frameEnd;
  logic [15:0]       rdData;
  logic [CW-1:0]     fifoCount;
  logic              fifoFull, fifoEmpty;
  logic              popValidReg;
  logic [31:0]       popCntReg;
  logic [31:0]       frameArea;
  logic              underflowReg;
  logic [UCNT_W-1:0] underCntReg;
  logic              frameErrReg;
  rgb888_t           pixOut;

  vga_feeder_fifo #(.DEPTH(DEPTH)) uFifo (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .iWrite   (wrEn),
    .iWr_Data (iIn_Data),
    .iRead    (rdEn),
    .iFlush   (flushEn),
    .oRd_Data (rdData),
    .oCount   (fifoCount),
    .oFull    (fifoFull),
    .oEmpty   (fifoEmpty)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) stateReg <= WAIT_SOF;
    else         stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    inReady   = 1'b0;
    wrEn      = 1'b0;
    rdEn      = 1'b0;
    flushEn   = 1'b0;
    underEv   = 1'b0;
    sofStart  = 1'b0;
    frameEnd  = 1'b0;
    case (stateReg)
      WAIT_SOF: begin
        // Everything is accepted here; only the SOF word is kept, the rest are dropped.
        inReady = readyEnReg;
        if (readyEnReg && iIn_Valid && iIn_SOF) begin
          wrEn      = 1'b1;
          sofStart  = 1'b1;
          stateNext = FILL;
        end
      end
      FILL: begin
        inReady = ~fifoFull;
        wrEn    = iIn_Valid & ~fifoFull;
        if (fifoCount >= PrefillCnt) stateNext = STREAM;
      end
      STREAM: begin
        inReady = ~fifoFull;
        // A word arriving with the frame-done strobe is discarded: the flush owns the FIFO.
        wrEn    = iIn_Valid & ~fifoFull & ~iFrameDone;
        if (iRequest) begin
          if (fifoEmpty) underEv = 1'b1;
          else           rdEn    = 1'b1;
        end
        if (iFrameDone) begin
          frameEnd  = 1'b1;
          stateNext = FLUSH;
        end
      end
      FLUSH: begin
        flushEn   = 1'b1;
        stateNext = WAIT_SOF;
      end
      default: stateNext = WAIT_SOF;
    endcase
  end

  assign frameArea = {16'd0, iVideo_W} * {16'd0, iVideo_H};

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      readyEnReg   <= 1'b0;
      popValidReg  <= 1'b0;
      popCntReg    <= '0;
      underflowReg <= 1'b0;
      underCntReg  <= '0;
      frameErrReg  <= 1'b0;
    end else begin
      // Keeps oIn_Ready low while reset is held and for the first cycle after release.
      readyEnReg  <= 1'b1;
      popValidReg <= rdEn;
      if (sofStart)  popCntReg <= '0;
      else if (rdEn) popCntReg <= popCntReg + 32'd1;
      if (underEv) underflowReg <= 1'b1;
      if (sofStart)
        underCntReg <= '0;
      else if (underEv && (underCntReg != {UCNT_W{1'b1}}))
        underCntReg <= underCntReg + UCNT_W'(1);
      // A pop in the frame-done cycle still belongs to the closing frame.
      if (frameEnd) frameErrReg <= ((popCntReg + 32'(rdEn)) != frameArea);
    end
  end

`ifdef VGA_FEEDER_PATTERN_EN
  // Column tracking follows every request served in STREAM (pop or underflow) so the bars stay
  // locked to screen position. The bar width is W/8; a per-bar pixel counter avoids a divider.
  logic [15:0] colReg;
  logic [15:0] barPixReg;
  logic [2:0]  barIdxReg;
  logic        patSelReg;
  rgb888_t     barRgbReg;
  logic [15:0] barWidth;
  logic        colStep;

  assign barWidth = {3'd0, iVideo_W[15:3]};
  assign colStep  = (stateReg == STREAM) && iRequest;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      colReg    <= '0;
      barPixReg <= '0;
      barIdxReg <= '0;
      patSelReg <= 1'b0;
      barRgbReg <= '0;
    end else begin
      if (rdEn) begin
        patSelReg <= iPattern;
        barRgbReg <= barColour(barIdxReg);
      end
      if (frameEnd) begin
        colReg    <= '0;
        barPixReg <= '0;
        barIdxReg <= '0;
      end else if (colStep) begin
        if (colReg == iVideo_W - 16'd1) begin
          colReg    <= '0;
          barPixReg <= '0;
          barIdxReg <= '0;
        end else begin
          colReg <= colReg + 16'd1;
          if (barPixReg + 16'd1 >= barWidth) begin
            barPixReg <= '0;
            barIdxReg <= barIdxReg + 3'd1;
          end else begin
            barPixReg <= barPixReg + 16'd1;
          end
        end
      end
    end
  end

  assign pixOut = !popValidReg ? rgb888_t'('0) :
                  (patSelReg ? barRgbReg : expand565(rdData));
`else
  // The FIFO read register is the pixel register; popValidReg zeroes non-popping cycles.
  assign pixOut = popValidReg ? expand565(rdData) : rgb888_t'('0);
`endif

  assign oIn_Ready  = inReady;
  assign oRed       = pixOut.red;
  assign oGreen     = pixOut.green;
  assign oBlue      = pixOut.blue;
  assign oUnderflow = underflowReg;
  assign oUnder_Cnt = underCntReg;
  assign oFrame_Err = frameErrReg;
  assign oState     = stateReg;

endmodule
